// File: rtl/layer_pkg.sv
// layer_pkg: shared definitions for the display layer sequencing logic.
//   - state_t      : game phase codes, also exported on gameState
//   - LAYER_*      : bit index of each drawing layer in the request vectors
//   - MASK_*       : per-phase layer visibility masks
//   - evt_t        : the three frame-latched game events
//   - layer_mask() : maps (state, blink phase) to the visibility mask
package layer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PLAY       = 3'd1,
        ST_HIT_BLINK  = 3'd2,
        ST_LEVEL_DONE = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_t;

    localparam int NUM_LAYERS   = 6;
    localparam int LAYER_PLAYER = 0;
    localparam int LAYER_ENEMY  = 1;
    localparam int LAYER_FRUIT  = 2;
    localparam int LAYER_SCORE  = 3;
    localparam int LAYER_BANNER = 4;
    localparam int LAYER_BG     = 5;

    localparam logic [NUM_LAYERS-1:0] MASK_IDLE       = 6'b110000;
    localparam logic [NUM_LAYERS-1:0] MASK_PLAY       = 6'b101111;
    // Player bit is filled in from the blink phase.
    localparam logic [NUM_LAYERS-1:0] MASK_HIT_BLINK  = 6'b101110;
    localparam logic [NUM_LAYERS-1:0] MASK_LEVEL_DONE = 6'b111000;
    localparam logic [NUM_LAYERS-1:0] MASK_GAME_OVER  = 6'b111000;

    typedef struct packed {
        logic levelDone;
        logic playerHit;
        logic startGame;
    } evt_t;

    function automatic logic [NUM_LAYERS-1:0] layer_mask(state_t st, logic phase);
        logic [NUM_LAYERS-1:0] m;
        m = MASK_IDLE;
        case (st)
            ST_IDLE:       m = MASK_IDLE;
            ST_PLAY:       m = MASK_PLAY;
            ST_HIT_BLINK: begin
                m = MASK_HIT_BLINK;
                m[LAYER_PLAYER] = phase;
            end
            ST_LEVEL_DONE: m = MASK_LEVEL_DONE;
            ST_GAME_OVER:  m = MASK_GAME_OVER;
            default:       m = MASK_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/frame_event_latch.sv
// frame_event_latch: holds one-cycle event pulses until the next frame start.
//   clk, resetN  : clock, async active-low reset (pending events are dropped)
//   startOfFrame : frame boundary; pending flags clear on this cycle
//   evtIn[W]     : one-cycle event pulses
//   evtOut[W]    : pending | evtIn, meaningful on the startOfFrame cycle so a
//                  pulse landing on the boundary cycle still counts this frame
module frame_event_latch #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         startOfFrame,
    input  logic [W-1:0] evtIn,
    output logic [W-1:0] evtOut
);

    logic [W-1:0] pend;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            pend <= '0;
        else if (startOfFrame)
            pend <= '0;
        else
            pend <= pend | evtIn;
    end

    assign evtOut = pend | evtIn;

endmodule

// File: rtl/layer_visibility_ctrl.sv
// layer_visibility_ctrl: frame-synchronous game phase sequencer that gates the
// six layer draw requests ahead of the priority mux.
//   clk, resetN        : clock, async active-low reset
//   startOfFrame       : one-cycle frame start pulse; all state moves here only
//   startGame/playerHit/levelDone : one-cycle event pulses, latched per frame
//   drawReqIn[6]       : raw layer requests (bit0 player .. bit5 background)
//   drawReqOut[6]      : drawReqIn & visibility mask, combinational
//   gameState[3]       : current phase code
//   livesLeft[3]       : remaining lives
//   playActive         : high only in PLAY
module layer_visibility_ctrl
    import layer_pkg::*;
#(
    parameter int INIT_LIVES   = 3,
    parameter int BLINK_FRAMES = 8,
    parameter int HIT_BLINKS   = 6,
    parameter int HOLD_FRAMES  = 120
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startGame,
    input  logic       playerHit,
    input  logic       levelDone,
    input  logic [5:0] drawReqIn,
    output logic [5:0] drawReqOut,
    output logic [2:0] gameState,
    output logic [2:0] livesLeft,
    output logic       playActive
);

    localparam int FC_MAX = (BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES;
    localparam int FC_W   = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;
    localparam int BC_W   = (HIT_BLINKS > 1) ? $clog2(HIT_BLINKS) : 1;

    evt_t evtRaw;
    evt_t evt;

    assign evtRaw.startGame = startGame;
    assign evtRaw.playerHit = playerHit;
    assign evtRaw.levelDone = levelDone;

    frame_event_latch #(.W(3)) u_evt (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .evtIn        (evtRaw),
        .evtOut       (evt)
    );

    state_t          state_q, state_d;
    logic [2:0]      lives_q, lives_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic [BC_W-1:0] bc_q, bc_d;
    logic            phase_q, phase_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            lives_q <= 3'(INIT_LIVES);
            fc_q    <= '0;
            bc_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            fc_q    <= fc_d;
            bc_q    <= bc_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        fc_d    = fc_q;
        bc_d    = bc_q;
        phase_d = phase_q;
        if (startOfFrame) begin
            case (state_q)
                ST_IDLE, ST_GAME_OVER: begin
                    if (evt.startGame) begin
                        state_d = ST_PLAY;
                        lives_d = 3'(INIT_LIVES);
                    end
                end
                ST_PLAY: begin
                    // Hit takes precedence; a simultaneous levelDone is dropped.
                    if (evt.playerHit) begin
                        state_d = ST_HIT_BLINK;
                        if (lives_q != 3'd0)
                            lives_d = lives_q - 3'd1;
                        phase_d = 1'b0;
                        fc_d    = '0;
                        bc_d    = '0;
                    end else if (evt.levelDone) begin
                        state_d = ST_LEVEL_DONE;
                        fc_d    = '0;
                    end
                end
                ST_HIT_BLINK: begin
                    if (fc_q == FC_W'(BLINK_FRAMES - 1)) begin
                        phase_d = ~phase_q;
                        fc_d    = '0;
                        bc_d    = bc_q + 1'b1;
                        // Lives were already taken on entry, so zero here means
                        // that was the last one.
                        if (bc_q == BC_W'(HIT_BLINKS - 1))
                            state_d = (lives_q == 3'd0) ? ST_GAME_OVER : ST_PLAY;
                    end else begin
                        fc_d = fc_q + 1'b1;
                    end
                end
                ST_LEVEL_DONE: begin
                    if (fc_q == FC_W'(HOLD_FRAMES - 1))
                        state_d = ST_PLAY;
                    else
                        fc_d = fc_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Mask is a pure function of registers that only move on the frame
    // boundary edge, so it is stable for a whole frame without its own flop.
    assign drawReqOut = drawReqIn & layer_mask(state_q, phase_q);
    assign gameState  = state_q;
    assign livesLeft  = lives_q;
    assign playActive = (state_q == ST_PLAY);

endmodule

// File: tb/tb_layer_visibility_ctrl.sv
module tb_layer_visibility_ctrl;

    localparam int INIT  = 2;
    localparam int BLINK = 2;
    localparam int HITB  = 4;
    localparam int HOLD  = 3;
    localparam int FLEN  = 4;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       startGame = 1'b0;
    logic       playerHit = 1'b0;
    logic       levelDone = 1'b0;
    logic [5:0] drawReqIn = 6'h3F;
    logic [5:0] drawReqOut;
    logic [2:0] gameState;
    logic [2:0] livesLeft;
    logic       playActive;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    layer_visibility_ctrl #(
        .INIT_LIVES(INIT), .BLINK_FRAMES(BLINK), .HIT_BLINKS(HITB), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .startGame(startGame), .playerHit(playerHit), .levelDone(levelDone),
        .drawReqIn(drawReqIn), .drawReqOut(drawReqOut), .gameState(gameState),
        .livesLeft(livesLeft), .playActive(playActive)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus "frames spent in the current phase".
    // Blink visibility and phase exits are derived from that frame count.
    int m_state = 0, m_lives = INIT, m_f = 0;
    bit pS = 0, pH = 0, pL = 0;
    int n_state, n_lives, n_f;
    bit eS, eH, eL;

    function automatic logic [5:0] mdl_mask(input int st, input int f);
        case (st)
            0:       return 6'b110000;
            1:       return 6'b101111;
            2:       return 6'b101110 | 6'(((f / BLINK) % 2));
            default: return 6'b111000;
        endcase
    endfunction

    always_comb begin
        eS = pS | startGame;
        eH = pH | playerHit;
        eL = pL | levelDone;
        n_state = m_state;
        n_lives = m_lives;
        n_f = m_f;
        if (startOfFrame) begin
            case (m_state)
                0, 4: if (eS) begin n_state = 1; n_lives = INIT; end
                1: begin
                    if (eH) begin
                        n_state = 2; n_f = 0;
                        n_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    end else if (eL) begin
                        n_state = 3; n_f = 0;
                    end
                end
                2: begin
                    n_f = m_f + 1;
                    if (n_f == BLINK * HITB) n_state = (m_lives == 0) ? 4 : 1;
                end
                3: begin
                    n_f = m_f + 1;
                    if (n_f == HOLD) n_state = 1;
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_state <= 0; m_lives <= INIT; m_f <= 0;
            pS <= 0; pH <= 0; pL <= 0;
        end else begin
            m_state <= n_state; m_lives <= n_lives; m_f <= n_f;
            pS <= startOfFrame ? 1'b0 : eS;
            pH <= startOfFrame ? 1'b0 : eH;
            pL <= startOfFrame ? 1'b0 : eL;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("drawReqOut", int'(drawReqOut), int'(drawReqIn & mdl_mask(m_state, m_f)));
            chk("gameState", int'(gameState), m_state);
            chk("livesLeft", int'(livesLeft), m_lives);
            chk("playActive", int'(playActive), int'(m_state == 1));
        end
    end

    // One cycle of inputs; returns at posedge+1.
    task automatic tick(input bit s, input bit sg, input bit ph, input bit ld);
        startOfFrame = s; startGame = sg; playerHit = ph; levelDone = ld;
        @(posedge clk); #1;
        startOfFrame = 0; startGame = 0; playerHit = 0; levelDone = 0;
    endtask

    // Event indices are cycles within the frame; FLEN-1 is the SOF cycle.
    task automatic frame(input int sgc = -1, input int hc = -1, input int lc = -1);
        for (int c = 0; c < FLEN; c++)
            tick(c == FLEN - 1, sgc == c, hc == c, lc == c);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        tick(0, 0, 0, 0);
        chk_en = 1'b1;
        tick(0, 1, 1, 1);   // events during reset are lost
        resetN = 1'b1;

        frames(3);
        chk("idle_state", int'(gameState), 0);
        chk("idle_out", int'(drawReqOut), 6'b110000);
        chk("idle_lives", int'(livesLeft), 2);

        frame(1);
        chk("play_state", int'(gameState), 1);
        chk("play_out", int'(drawReqOut), 6'b101111);
        chk("play_active", int'(playActive), 1);

        frame(-1, 2);
        chk("hit1_lives", int'(livesLeft), 1);
        chk("hit1_out", int'(drawReqOut), 6'b101110);
        frames(2);
        chk("blink_on", int'(drawReqOut), 6'b101111);
        frames(2);
        chk("blink_off", int'(drawReqOut), 6'b101110);
        frames(4);
        chk("hit1_exit", int'(gameState), 1);

        frame(-1, 0);
        chk("hit2_lives", int'(livesLeft), 0);
        frames(8);
        chk("over_state", int'(gameState), 4);
        chk("over_out", int'(drawReqOut), 6'b111000);
        frame(FLEN - 1);    // startGame on the SOF cycle itself
        chk("restart_state", int'(gameState), 1);
        chk("restart_lives", int'(livesLeft), 2);

        frame(-1, 1, 1);
        chk("hit_wins", int'(gameState), 2);
        frames(8);
        chk("hit_wins_exit", int'(gameState), 1);

        frame(-1, -1, 2);
        chk("ld_enter", int'(gameState), 3);
        frames(2);
        chk("ld_hold", int'(gameState), 3);
        frame();
        chk("ld_exit", int'(gameState), 1);

        frame(-1, 0);
        chk("hit3_state", int'(gameState), 2);
        tick(0, 1, 0, 0);   // startGame pending when reset hits
        resetN = 1'b0;
        #1;
        chk("rst_state", int'(gameState), 0);
        chk("rst_out", int'(drawReqOut), 6'b110000);
        chk("rst_lives", int'(livesLeft), 2);
        tick(0, 1, 1, 0);
        resetN = 1'b1;
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("rst_no_pending", int'(gameState), 0);

        // Randomized phase: sparse events, random requests, occasional reset.
        for (int fr = 0; fr < 300; fr++) begin
            int rc;
            rc = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, FLEN - 1)) : -1;
            for (int c = 0; c < FLEN; c++) begin
                drawReqIn = 6'($urandom);
                if (c == rc) resetN = 1'b0;
                tick(c == FLEN - 1, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
                resetN = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_visibility_ctrl.md
# layer_visibility_ctrl

Frame-synchronous controller that sequences the game display by gating the six per-layer draw requests before they reach the six-input priority drawing mux. It tracks the game phase (title, play, hit-blink, level-done, game-over), keeps the lives count, and produces a per-layer visibility mask. The mask changes only on frame boundaries, so no layer tears mid-frame. Sits between the object drawers and the priority mux; its gated outputs connect one-to-one to the mux request inputs.

## Interface
Parameters:
- INIT_LIVES, 3: lives loaded on reset and on startGame.
- BLINK_FRAMES, 8: frames per blink half-period in HIT_BLINK.
- HIT_BLINKS, 6: player visibility toggles per hit sequence.
- HOLD_FRAMES, 120: frames the LEVEL_DONE banner is held.

Ports:
- clk, in, 1: system clock.
- resetN, in, 1: reset, asynchronous, active-low.
- startOfFrame, in, 1: one-cycle pulse at frame start.
- startGame, in, 1: one-cycle event pulse.
- playerHit, in, 1: one-cycle event pulse.
- levelDone, in, 1: one-cycle event pulse.
- drawReqIn, in, 6: raw layer requests. Bit0 is player (mux priority 1), bit1 enemies, bit2 fruits, bit3 score, bit4 banner text, bit5 background.
- drawReqOut, out, 6: drawReqIn & mask, combinational, zero latency.
- gameState, out, 3: current state code.
- livesLeft, out, 3: remaining lives.
- playActive, out, 1: high only in PLAY. Object movers freeze when it is low.

## Operation
- States and codes: IDLE=0, PLAY=1, HIT_BLINK=2, LEVEL_DONE=3, GAME_OVER=4.
- Masks:
  - IDLE: 6'b110000.
  - PLAY: 6'b101111.
  - HIT_BLINK: 6'b10111p, where p is the blink phase.
  - LEVEL_DONE and GAME_OVER: 6'b111000.
- Event latching: each event pulse sets a pending flag. The flags are consumed, then cleared, on the next startOfFrame. An event that coincides with the startOfFrame cycle counts for that frame.
- Transitions are evaluated only on startOfFrame cycles:
  - IDLE or GAME_OVER + startGame → PLAY. Lives are reloaded to INIT_LIVES.
  - PLAY + hit → HIT_BLINK. Entry actions: lives decrement by 1, phase=0 (player hidden), frameCnt=0, blinkCnt=0.
  - PLAY + levelDone, with no hit → LEVEL_DONE, frameCnt=0.
  - HIT_BLINK: frameCnt increments each frame. When frameCnt reaches BLINK_FRAMES-1, the block toggles phase, clears frameCnt and increments blinkCnt.
  - HIT_BLINK exit: on the toggle where blinkCnt==HIT_BLINKS-1, the block goes to GAME_OVER if livesLeft==0, otherwise to PLAY.
  - LEVEL_DONE → PLAY after HOLD_FRAMES frames, i.e. when frameCnt==HOLD_FRAMES-1.
- Simultaneous hit and levelDone in PLAY: hit wins, and levelDone is discarded.
- Events that do not apply to the current state are discarded at the frame boundary. startGame during PLAY is ignored.
- livesLeft saturates at 0 and never wraps.

## Timing
- Reset values:
  - state=IDLE, mask=6'b110000, livesLeft=INIT_LIVES.
  - All counters, phase and pending flags are 0.
  - playActive=0, gameState=0.
  - drawReqOut = drawReqIn & 6'b110000.
- Reset is asynchronous. Asserting it mid-sequence aborts immediately to the reset values. Events arriving during reset are lost.
- State, mask, counters and lives register on the clk edge of the startOfFrame cycle. The new mask applies from the next cycle, for the whole frame.
- drawReqOut has 0-cycle latency from drawReqIn. The downstream mux adds its one register stage.
- No state change occurs between startOfFrame pulses.
- frameCnt width is $clog2(max(BLINK_FRAMES, HOLD_FRAMES)). blinkCnt width is $clog2(HIT_BLINKS).

## Structure
- Shared package layer_pkg holds:
  - the state enum;
  - the layer-index constants (LAYER_PLAYER=0 … LAYER_BG=5);
  - the five mask constants.
- One sub-module, frame_event_latch: per-event pending flags with clear-on-startOfFrame. It is instantiated once with width 3.
- The top level holds the FSM, counters, lives register and mask AND.

## Test plan
Bench parameters: INIT_LIVES=2, BLINK_FRAMES=2, HIT_BLINKS=4, HOLD_FRAMES=3. drawReqIn=6'h3F throughout.
- Reset, then 3 frames with no events → gameState=0, drawReqOut=6'b110000, livesLeft=2.
- startGame mid-frame, then startOfFrame → from the next cycle gameState=1, drawReqOut=6'b101111, playActive=1.
- In PLAY, playerHit → next frame livesLeft=1, out=6'b101110. Bit0 then toggles every 2 frames for 4 toggles, followed by PLAY.
- Second hit with livesLeft=1 → blink sequence, then GAME_OVER (gameState=4, out=6'b111000). startGame → PLAY, livesLeft=2.
- playerHit and levelDone in the same frame → HIT_BLINK, and LEVEL_DONE is never entered. levelDone alone → LEVEL_DONE for 3 frames, then PLAY.
- resetN low mid-HIT_BLINK → immediate IDLE, out=6'b110000, livesLeft=2, and the event pending before reset has no effect.
